// File: rtl/hazard3_timer_apb_arbiter.sv
// hazard3_timer_apb_arbiter
// Shares the machine-timer APB slave port between hart 0 and hart 1.
// Round-robin grant, one full downstream transfer per grant, response
// returned to the winner only, then one idle cycle before the next grant.
// Optional ACCESS-phase timeout: define HAZARD3_TIMER_ARB_TIMEOUT_EN.
module hazard3_timer_apb_arbiter #(
  parameter int W_PADDR        = 16,
  parameter int W_DATA         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  // hart 0 upstream
  input  logic               s0_psel,
  input  logic               s0_penable,
  input  logic               s0_pwrite,
  input  logic [W_PADDR-1:0] s0_paddr,
  input  logic [W_DATA-1:0]  s0_pwdata,
  output logic [W_DATA-1:0]  s0_prdata,
  output logic               s0_pready,
  output logic               s0_pslverr,
  // hart 1 upstream
  input  logic               s1_psel,
  input  logic               s1_penable,
  input  logic               s1_pwrite,
  input  logic [W_PADDR-1:0] s1_paddr,
  input  logic [W_DATA-1:0]  s1_pwdata,
  output logic [W_DATA-1:0]  s1_prdata,
  output logic               s1_pready,
  output logic               s1_pslverr,
  // downstream timer
  output logic               m_psel,
  output logic               m_penable,
  output logic               m_pwrite,
  output logic [W_PADDR-1:0] m_paddr,
  output logic [W_DATA-1:0]  m_pwdata,
  output logic [W_DATA-1:0]  m_phartid,
  input  logic [W_DATA-1:0]  m_prdata,
  input  logic               m_pready,
  input  logic               m_pslverr
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  // Upstream penable is deliberately ignored: a request is psel alone.
  logic unused_inputs;
  assign unused_inputs = ^{s0_penable, s1_penable, 5'(TIMEOUT_CYCLES)};

  // Per-hart views of the upstream requests, indexed by hart ID.
  logic [1:0]         req;
  logic [1:0]         req_write;
  logic [W_PADDR-1:0] req_addr  [2];
  logic [W_DATA-1:0]  req_wdata [2];

  assign req          = {s1_psel, s0_psel};
  assign req_write    = {s1_pwrite, s0_pwrite};
  assign req_addr[0]  = s0_paddr;
  assign req_addr[1]  = s1_paddr;
  assign req_wdata[0] = s0_pwdata;
  assign req_wdata[1] = s1_pwdata;

  logic [2:0]         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               winner_q, winner_d;
  logic [W_PADDR-1:0] cap_addr_q, cap_addr_d;
  logic               cap_write_q, cap_write_d;
  logic [W_DATA-1:0]  cap_wdata_q, cap_wdata_d;

  logic               m_psel_q, m_penable_q;
  logic               grant_hart;
  logic               timeout_hit;
  logic               rsp_load;
  logic [W_DATA-1:0]  rsp_data;
  logic               rsp_err;
  logic [1:0]         winner_oh;

  assign winner_oh = {winner_q, ~winner_q};

  // Round-robin choice: a lone requester wins, a tie goes to the hart
  // that was not granted last.
  always_comb begin
    grant_hart = 1'b0;
    case (req)
      2'b01:   grant_hart = 1'b0;
      2'b10:   grant_hart = 1'b1;
      2'b11:   grant_hart = ~last_grant_q;
      default: grant_hart = 1'b0;
    endcase
  end

`ifdef HAZARD3_TIMER_ARB_TIMEOUT_EN
  logic [4:0] tmo_cnt_q, tmo_cnt_d;

  // Count ACCESS cycles without pready; cleared while in SETUP so it
  // starts at zero on entry to ACCESS.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !m_pready) begin
      tmo_cnt_d = tmo_cnt_q + 5'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // The limit fires on the cycle the count would reach TIMEOUT_CYCLES;
  // a pready on that same cycle wins and completes normally.
  assign timeout_hit = (state_q == ST_ACCESS) && !m_pready &&
                       (tmo_cnt_q == 5'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Response latched at the end of ACCESS: writes return zero data,
  // a timeout returns zero data with an error.
  assign rsp_load = (state_q == ST_ACCESS) && (m_pready || timeout_hit);
  assign rsp_data = (timeout_hit || cap_write_q) ? '0 : m_prdata;
  assign rsp_err  = timeout_hit | m_pslverr;

  // Transfer sequencing and capture of the winner's request at grant.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cap_addr_d   = cap_addr_q;
    cap_write_d  = cap_write_q;
    cap_wdata_d  = cap_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d      = ST_SETUP;
          winner_d     = grant_hart;
          last_grant_d = grant_hart;
          cap_addr_d   = req_addr[grant_hart];
          cap_write_d  = req_write[grant_hart];
          cap_wdata_d  = req_wdata[grant_hart];
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (rsp_load) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, capture and downstream strobe registers; the strobes are
  // decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_write_q  <= 1'b0;
      cap_wdata_q  <= '0;
      m_psel_q     <= 1'b0;
      m_penable_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cap_addr_q   <= cap_addr_d;
      cap_write_q  <= cap_write_d;
      cap_wdata_q  <= cap_wdata_d;
      m_psel_q     <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      m_penable_q  <= (state_d == ST_ACCESS);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hart
      logic              pready_q;
      logic [W_DATA-1:0] prdata_q;
      logic              pslverr_q;

      // Per-hart response: pready only during DONE for the winner; data
      // and error hold their last value between transfers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
        end else begin
          pready_q <= (state_d == ST_DONE) && winner_oh[gi];
          if (rsp_load && winner_oh[gi]) begin
            prdata_q  <= rsp_data;
            pslverr_q <= rsp_err;
          end
        end
      end
    end
  endgenerate

  assign s0_pready  = g_hart[0].pready_q;
  assign s0_prdata  = g_hart[0].prdata_q;
  assign s0_pslverr = g_hart[0].pslverr_q;
  assign s1_pready  = g_hart[1].pready_q;
  assign s1_prdata  = g_hart[1].prdata_q;
  assign s1_pslverr = g_hart[1].pslverr_q;

  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = cap_write_q;
  assign m_paddr   = cap_addr_q;
  assign m_pwdata  = cap_wdata_q;
  assign m_phartid = {{(W_DATA-1){1'b0}}, winner_q};

endmodule

// File: tb/tb_hazard3_timer_apb_arbiter.sv
// Bench for hazard3_timer_apb_arbiter: directed scenarios plus random
// two-hart traffic, checked against a round-robin / register-file model.
// Build with HAZARD3_TIMER_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_hazard3_timer_apb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Upstream stimulus, per hart.
  logic [1:0]  psel_r = 2'b00;
  logic [15:0] t_addr [2];
  logic        t_wr   [2];
  logic [31:0] t_wd   [2];

  logic [31:0] s0_prdata, s1_prdata, m_pwdata, m_phartid, m_prdata;
  logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [15:0] m_paddr;

  // Timer stand-in: one wait state, 16 words, errors above 0x3C,
  // and a write to 0x0004 drives the soft IRQ of the tagged hart.
  logic        stall = 1'b0;
  logic        tpready_q;
  logic [31:0] tmem [16];
  logic [1:0]  soft_irq;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] mmem [16];
  logic        last_m;
  int          setup_log [$];

  hazard3_timer_apb_arbiter #(.W_PADDR(16), .W_DATA(32), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_psel(psel_r[0]), .s0_penable(psel_r[0]), .s0_pwrite(t_wr[0]),
    .s0_paddr(t_addr[0]), .s0_pwdata(t_wd[0]),
    .s0_prdata(s0_prdata), .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
    .s1_psel(psel_r[1]), .s1_penable(psel_r[1]), .s1_pwrite(t_wr[1]),
    .s1_paddr(t_addr[1]), .s1_pwdata(t_wd[1]),
    .s1_prdata(s1_prdata), .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_phartid(m_phartid),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  assign m_prdata  = tmem[m_paddr[5:2]];
  assign m_pslverr = (m_paddr >= 16'h0040);
  assign m_pready  = tpready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpready_q <= 1'b0;
      soft_irq  <= 2'b00;
      for (int i = 0; i < 16; i++) tmem[i] <= init_word(i);
    end else begin
      tpready_q <= m_psel && m_penable && !tpready_q && !stall;
      if (m_psel && m_penable && tpready_q && m_pwrite && (m_paddr < 16'h0040)) begin
        tmem[m_paddr[5:2]] <= m_pwdata;
        if (m_paddr == 16'h0004) soft_irq[m_phartid[0]] <= m_pwdata[0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
    last_m = 1'b1;
  endtask

  task automatic do_reset();
    psel_r = 2'b00;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn(input int h);
    t_addr[h] = 16'($urandom_range(0, 31) << 2);
    t_wr[h]   = 1'($urandom_range(0, 1));
    t_wd[h]   = $urandom;
  endtask

  // Drive n0/n1 transfers per hart (re-requesting right after each
  // completion) and check grants, downstream fields and responses.
  task automatic run_traffic(input int n0, input int n1, input int budget);
    int          left [2];
    int          cur;
    bit          busy;
    bit          seen_setup;
    int          lowrun;
    int          cyc;
    logic [1:0]  pend_prev;
    logic        w;
    logic        rdy;
    logic [31:0] rdata;
    logic        rerr;
    logic [31:0] exp_data;
    logic        exp_err;
    left[0] = n0;
    left[1] = n1;
    psel_r = {n1 > 0, n0 > 0};
    busy = 0; cur = 0; seen_setup = 0; lowrun = 0; cyc = 0;
    setup_log.delete();
    while ((left[0] > 0 || left[1] > 0 || busy) && cyc < budget) begin
      pend_prev = psel_r;
      @(posedge clk);
      #1;
      cyc++;
      chk("single_pready", 32'(s0_pready & s1_pready), 0);
      if (m_psel && !m_penable) begin
        chk("grant_had_request", 32'(pend_prev != 2'b00), 1);
        w = (pend_prev == 2'b11) ? ~last_m : pend_prev[1];
        last_m = w;
        cur = int'(w);
        busy = 1;
        setup_log.push_back(cyc);
        chk("phartid", m_phartid, 32'(w));
        chk("paddr", 32'(m_paddr), 32'(t_addr[w]));
        chk("pwrite", 32'(m_pwrite), 32'(t_wr[w]));
        if (t_wr[w]) chk("pwdata", m_pwdata, t_wd[w]);
        if (seen_setup) chk("idle_gap_ge2", 32'(lowrun >= 2), 1);
        seen_setup = 1;
      end
      lowrun = m_psel ? 0 : lowrun + 1;
      for (int h = 0; h < 2; h++) begin
        rdy   = (h == 0) ? s0_pready  : s1_pready;
        rdata = (h == 0) ? s0_prdata  : s1_prdata;
        rerr  = (h == 0) ? s0_pslverr : s1_pslverr;
        if (rdy) begin
          chk("pready_owner", 32'(busy && cur == h), 1);
          exp_err  = (t_addr[h] >= 16'h0040);
          exp_data = t_wr[h] ? 32'h0 : mmem[t_addr[h][5:2]];
          chk("prdata", rdata, exp_data);
          chk("pslverr", 32'(rerr), 32'(exp_err));
          if (t_wr[h] && !exp_err) mmem[t_addr[h][5:2]] = t_wd[h];
          $display("txn hart=%0d %s addr=%h wdata=%h rdata=%h err=%0d", h,
                   t_wr[h] ? "WR" : "RD", t_addr[h], t_wd[h], rdata, rerr);
          busy = 0;
          left[h]--;
          if (left[h] > 0) new_txn(h);
          else psel_r[h] = 1'b0;
        end
      end
    end
    chk("traffic_in_budget", 32'(left[0] == 0 && left[1] == 0 && !busy), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    bit   seen;
    int   done_k;
    logic [31:0] got_data;
    logic got_err;

    for (int h = 0; h < 2; h++) begin
      t_addr[h] = '0; t_wr[h] = 1'b0; t_wd[h] = '0;
    end

    // Reset state.
    do_reset();
    chk("reset_outputs_zero",
        32'(|{s0_prdata, s0_pready, s0_pslverr, s1_prdata, s1_pready, s1_pslverr,
              m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_phartid}), 0);

    // Simultaneous requests right after reset: hart 0 first, hart 1 at cycle 7.
    t_addr[0] = 16'h0008; t_wr[0] = 1'b0;
    t_addr[1] = 16'h000C; t_wr[1] = 1'b0;
    run_traffic(1, 1, 40);
    chk("first_setup_cycle", 32'(setup_log.size() > 0 ? setup_log[0] : -1), 1);
    chk("second_setup_cycle", 32'(setup_log.size() > 1 ? setup_log[1] : -1), 7);

    // Uncontended hart 0 write with exact cycle timing.
    do_reset();
    t_addr[0] = 16'h0010; t_wr[0] = 1'b1; t_wd[0] = 32'h1234_5678;
    psel_r = 2'b01;
    for (k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("setup_psel", 32'(m_psel), 1);
        chk("setup_penable", 32'(m_penable), 0);
        chk("setup_paddr", 32'(m_paddr), 32'h0010);
        chk("setup_pwdata", m_pwdata, 32'h1234_5678);
        chk("setup_phartid", m_phartid, 0);
      end
      if (k == 2) chk("access_penable", 32'(m_penable), 1);
      chk($sformatf("s0_pready_cycle%0d", k), 32'(s0_pready), 32'(k == 4));
      if (k == 4) begin
        chk("write_pslverr", 32'(s0_pslverr), 0);
        chk("write_prdata", s0_prdata, 0);
        psel_r = 2'b00;
      end
    end
    mmem[4] = 32'h1234_5678;
    last_m  = 1'b0;
    t_wr[0] = 1'b0;
    run_traffic(1, 0, 20);

    // Continuous contention: 8 alternating transfers.
    new_txn(0); new_txn(1);
    run_traffic(4, 4, 120);

    // IPI write from hart 1, then read back from hart 0.
    t_addr[1] = 16'h0004; t_wr[1] = 1'b1; t_wd[1] = 32'h1;
    run_traffic(0, 1, 20);
    chk("soft_irq1", 32'(soft_irq[1]), 1);
    t_addr[0] = 16'h0004; t_wr[0] = 1'b0;
    run_traffic(1, 0, 20);

    // Random traffic rounds.
    for (int r = 0; r < 12; r++) begin
      new_txn(0); new_txn(1);
      run_traffic($urandom_range(0, 3), $urandom_range(0, 3), 150);
    end

    // Reset asserted during ACCESS.
    repeat (2) @(posedge clk);
    #1;
    t_addr[0] = 16'h0010; t_wr[0] = 1'b0;
    psel_r = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_in_access", 32'(m_psel & m_penable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs_zero",
        32'(|{s0_prdata, s0_pready, s0_pslverr, s1_prdata, s1_pready, s1_pslverr,
              m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_phartid}), 0);
    do_reset();
    t_addr[0] = 16'h0008; t_wr[0] = 1'b0;
    run_traffic(1, 0, 20);

    // Timer never answers.
    repeat (2) @(posedge clk);
    #1;
    stall = 1'b1;
    t_addr[0] = 16'h0008; t_wr[0] = 1'b0;
    psel_r = 2'b01;
    seen = 0; done_k = 0; got_data = 32'hDEAD_BEEF; got_err = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (s0_pready && !seen) begin
        seen = 1; done_k = k; got_data = s0_prdata; got_err = s0_pslverr;
        psel_r = 2'b00;
      end
    end
`ifdef HAZARD3_TIMER_ARB_TIMEOUT_EN
    chk("timeout_seen", 32'(seen), 1);
    chk("timeout_cycle", 32'(done_k), 17);
    chk("timeout_pslverr", 32'(got_err), 1);
    chk("timeout_prdata", got_data, 0);
`else
    chk("no_completion_while_stalled", 32'(seen), 0);
`endif
    stall = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
